dht_query_scheduler: RTL and testbench

- Sequences single-sensor DHT11 reads on the shared multi-sensor reader (start_bit / currentSensor / done / errorSensor interface).
- Accepts one query at a time from the host command path. Rejects bad sensors and bad commands.
- Enforces a per-sensor minimum re-read interval, verifies the checksum, guards against a stuck reader with a watchdog, and returns a coded response.

---
 rtl/dht_sched_pkg.sv | 38 +++
 rtl/dht_holdoff_bank.sv | 44 ++++
 rtl/dht_query_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_dht_query_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_sched_pkg.sv
// Shared types and constants for the DHT11 query scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, response codes, host command encodings and
// the reader byte bundle captured on rd_done.
package dht_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    START   = 3'd2,
    WAIT_RD = 3'd3,
    EVAL    = 3'd4,
    RESPOND = 3'd5
  } state_t;

  localparam logic [7:0] RC_OK         = 8'h00;
  localparam logic [7:0] RC_SENSOR_ERR = 8'h01;
  localparam logic [7:0] RC_CSUM_ERR   = 8'h02;
  localparam logic [7:0] RC_TIMEOUT    = 8'h03;
  localparam logic [7:0] RC_BAD_SENSOR = 8'h04;
  localparam logic [7:0] RC_HOLDOFF    = 8'h05;
  localparam logic [7:0] RC_BAD_CMD    = 8'h06;

  localparam logic [1:0] CMD_TEMP = 2'd0;
  localparam logic [1:0] CMD_HUM  = 2'd1;
  localparam logic [1:0] CMD_CSUM = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_float;
    logic [7:0] temp_int;
    logic [7:0] temp_float;
    logic [7:0] check_sum;
  } rd_bytes_t;

endpackage

// File: rtl/dht_holdoff_bank.sv
// Per-sensor re-read holdoff counters.
// Latency: load visible on busy the cycle after load; decrement one per ms_tick.
// Backpressure: none; load and ms_tick are accepted every cycle.
// Ports: clk, reset_n (async, active-low), ms_tick (1 ms pulse),
//   load/load_idx (restart holdoff for one sensor), busy (counter nonzero).
module dht_holdoff_bank #(
  parameter int NUM_SENSORS = 4,
  parameter int SENSOR_W    = 5,
  parameter int HOLD_W      = 11,
  parameter int HOLDOFF_MS  = 2000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ms_tick,
  input  logic                   load,
  input  logic [SENSOR_W-1:0]    load_idx,
  output logic [NUM_SENSORS-1:0] busy
);

  logic [HOLD_W-1:0] cnt_q [NUM_SENSORS];
  logic [HOLD_W-1:0] cnt_d [NUM_SENSORS];

  always_comb begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      cnt_d[i] = cnt_q[i];
      busy[i]  = (cnt_q[i] != '0);
      // A load on the same cycle as ms_tick restarts the full interval.
      if (load && (load_idx == SENSOR_W'(i))) begin
        cnt_d[i] = HOLD_W'(HOLDOFF_MS);
      end else if (ms_tick && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SENSORS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/dht_query_scheduler.sv
// Sequences one DHT11 read per host query on the shared sensor reader.
// Latency: reject -> rsp_valid 2 cycles after request; read -> 2 cycles after rd_done.
// Backpressure: one query in flight; req_ready low until the response is taken.
// Ports: req_* (host query, valid/ready), rsp_* (coded response, valid/ready),
//   rd_* (reader start/select, done/error and data bytes), ms_tick (1 ms pulse).
module dht_query_scheduler
  import dht_sched_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter int SENSOR_W    = 5,
  parameter int HOLDOFF_MS  = 2000,
  parameter int HOLD_W      = 11,
  parameter int TIMEOUT_CYC = 30000,
  parameter int TO_W        = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ms_tick,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SENSOR_W-1:0] req_sensor,
  input  logic [1:0]          req_cmd,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SENSOR_W-1:0] rsp_sensor,
  output logic [7:0]          rsp_code,
  output logic [15:0]         rsp_data,
  output logic                rd_start,
  output logic [SENSOR_W-1:0] rd_sensor,
  input  logic                rd_done,
  input  logic                rd_error,
  input  logic [7:0]          rd_hum_int,
  input  logic [7:0]          rd_hum_float,
  input  logic [7:0]          rd_temp_int,
  input  logic [7:0]          rd_temp_float,
  input  logic [7:0]          rd_check_sum
);

  state_t              state_q, state_d;
  logic [SENSOR_W-1:0] sensor_q, sensor_d;
  logic [1:0]          cmd_q, cmd_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [7:0]          rsp_code_q, rsp_code_d;
  logic [15:0]         rsp_data_q, rsp_data_d;
  logic [SENSOR_W-1:0] rsp_sensor_q, rsp_sensor_d;
  logic                rd_start_q, rd_start_d;
  logic [SENSOR_W-1:0] rd_sensor_q, rd_sensor_d;
  logic [TO_W-1:0]     wdog_q, wdog_d;
  rd_bytes_t           rd_bytes_q, rd_bytes_d;
  logic                rd_err_q, rd_err_d;

  logic                   hold_load;
  logic [NUM_SENSORS-1:0] hold_busy;
  logic                   sel_busy;
  logic [7:0]             csum_calc;
  logic [15:0]            sel_data;

  dht_holdoff_bank #(
    .NUM_SENSORS (NUM_SENSORS),
    .SENSOR_W    (SENSOR_W),
    .HOLD_W      (HOLD_W),
    .HOLDOFF_MS  (HOLDOFF_MS)
  ) u_holdoff (
    .clk      (clk),
    .reset_n  (reset_n),
    .ms_tick  (ms_tick),
    .load     (hold_load),
    .load_idx (sensor_q),
    .busy     (hold_busy)
  );

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_code   = rsp_code_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_sensor = rsp_sensor_q;
  assign rd_start   = rd_start_q;
  assign rd_sensor  = rd_sensor_q;

  always_comb begin
    state_d      = state_q;
    sensor_d     = sensor_q;
    cmd_d        = cmd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_code_d   = rsp_code_q;
    rsp_data_d   = rsp_data_q;
    rsp_sensor_d = rsp_sensor_q;
    rd_start_d   = 1'b0;
    rd_sensor_d  = rd_sensor_q;
    wdog_d       = wdog_q;
    rd_bytes_d   = rd_bytes_q;
    rd_err_d     = rd_err_q;
    hold_load    = 1'b0;

    // Compare-based select keeps an out-of-range index from reaching the vector.
    sel_busy = 1'b0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (sensor_q == SENSOR_W'(i)) sel_busy = hold_busy[i];
    end

    csum_calc = rd_bytes_q.hum_int + rd_bytes_q.hum_float
              + rd_bytes_q.temp_int + rd_bytes_q.temp_float;

    case (cmd_q)
      CMD_TEMP: sel_data = {rd_bytes_q.temp_int, rd_bytes_q.temp_float};
      CMD_HUM:  sel_data = {rd_bytes_q.hum_int, rd_bytes_q.hum_float};
      CMD_CSUM: sel_data = {8'h00, rd_bytes_q.check_sum};
      default:  sel_data = 16'h0000;
    endcase

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          sensor_d = req_sensor;
          cmd_d    = req_cmd;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        rsp_sensor_d = sensor_q;
        rsp_data_d   = 16'h0000;
        if (sensor_q >= SENSOR_W'(NUM_SENSORS)) begin
          rsp_code_d  = RC_BAD_SENSOR;
          rsp_valid_d = 1'b1;
          state_d     = RESPOND;
        end else if (cmd_q == CMD_RSVD) begin
          rsp_code_d  = RC_BAD_CMD;
          rsp_valid_d = 1'b1;
          state_d     = RESPOND;
        end else if (sel_busy) begin
          rsp_code_d  = RC_HOLDOFF;
          rsp_valid_d = 1'b1;
          state_d     = RESPOND;
        end else begin
          rd_sensor_d = sensor_q;
          rd_start_d  = 1'b1;   // high for the single START cycle
          state_d     = START;
        end
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        // Reader bytes are captured so EVAL does not depend on them staying put.
        if (rd_done) begin
          rd_bytes_d = '{rd_hum_int, rd_hum_float, rd_temp_int, rd_temp_float, rd_check_sum};
          rd_err_d   = rd_error;
          state_d    = EVAL;
        end else if (wdog_q == TO_W'(TIMEOUT_CYC - 1)) begin
          hold_load    = 1'b1;
          rsp_sensor_d = sensor_q;
          rsp_code_d   = RC_TIMEOUT;
          rsp_data_d   = 16'h0000;
          rsp_valid_d  = 1'b1;
          state_d      = RESPOND;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      EVAL: begin
        hold_load    = 1'b1;
        rsp_sensor_d = sensor_q;
        rsp_data_d   = sel_data;
        rsp_valid_d  = 1'b1;
        if (rd_err_q)                                rsp_code_d = RC_SENSOR_ERR;
        else if (csum_calc != rd_bytes_q.check_sum) rsp_code_d = RC_CSUM_ERR;
        else                                         rsp_code_d = RC_OK;
        state_d = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sensor_q     <= '0;
      cmd_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_code_q   <= '0;
      rsp_data_q   <= '0;
      rsp_sensor_q <= '0;
      rd_start_q   <= 1'b0;
      rd_sensor_q  <= '0;
      wdog_q       <= '0;
      rd_bytes_q   <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sensor_q     <= sensor_d;
      cmd_q        <= cmd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_code_q   <= rsp_code_d;
      rsp_data_q   <= rsp_data_d;
      rsp_sensor_q <= rsp_sensor_d;
      rd_start_q   <= rd_start_d;
      rd_sensor_q  <= rd_sensor_d;
      wdog_q       <= wdog_d;
      rd_bytes_q   <= rd_bytes_d;
      rd_err_q     <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_dht_query_scheduler.sv
// Directed bench for dht_query_scheduler with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dht_query_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ms_tick;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_sensor;
  logic [1:0]  req_cmd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_sensor;
  logic [7:0]  rsp_code;
  logic [15:0] rsp_data;
  logic        rd_start;
  logic [4:0]  rd_sensor;
  logic        rd_done;
  logic        rd_error;
  logic [7:0]  rd_hum_int, rd_hum_float, rd_temp_int, rd_temp_float, rd_check_sum;

  int n_vec = 0;
  int n_err = 0;
  int start_cyc = 0;

  always #5 clk = ~clk;

  dht_query_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ms_tick       (ms_tick),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sensor    (req_sensor),
    .req_cmd       (req_cmd),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_sensor    (rsp_sensor),
    .rsp_code      (rsp_code),
    .rsp_data      (rsp_data),
    .rd_start      (rd_start),
    .rd_sensor     (rd_sensor),
    .rd_done       (rd_done),
    .rd_error      (rd_error),
    .rd_hum_int    (rd_hum_int),
    .rd_hum_float  (rd_hum_float),
    .rd_temp_int   (rd_temp_int),
    .rd_temp_float (rd_temp_float),
    .rd_check_sum  (rd_check_sum)
  );

  // Counts cycles with rd_start high, so a read must add exactly one.
  always @(negedge clk) if (rd_start === 1'b1) start_cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a query for one cycle; returns on the falling edge of the CHECK cycle.
  task automatic send_req(input logic [4:0] s, input logic [1:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid  = 1'b1;
    req_sensor = s;
    req_cmd    = c;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic expect_reject_latency(input string tag);
    chk({tag, "_lat1"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_lat2"}, rsp_valid, 1'b1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (rd_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, rd_start, 1'b1);
  endtask

  // Reader model: waits for rd_start, then pulses rd_done after a delay.
  task automatic run_read(input string tag, input logic [4:0] s, input logic err,
                          input logic [7:0] hi, input logic [7:0] hf,
                          input logic [7:0] ti, input logic [7:0] tf,
                          input logic [7:0] cs);
    wait_start(tag);
    chk({tag, "_rd_sensor"}, rd_sensor, s);
    repeat (6) @(negedge clk);
    chk({tag, "_rd_sensor_hold"}, rd_sensor, s);
    rd_hum_int = hi; rd_hum_float = hf; rd_temp_int = ti; rd_temp_float = tf;
    rd_check_sum = cs; rd_error = err; rd_done = 1'b1;
    @(negedge clk);
    rd_done  = 1'b0;
    rd_error = 1'b0;
    chk({tag, "_lat1"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_lat2"}, rsp_valid, 1'b1);
  endtask

  task automatic take_rsp(input string tag, input logic [7:0] code,
                          input logic [15:0] data, input logic [4:0] s);
    chk({tag, "_code"}, rsp_code, code);
    chk({tag, "_data"}, rsp_data, data);
    chk({tag, "_sensor"}, rsp_sensor, s);
    chk({tag, "_rdy_low"}, req_ready, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_vld_drop"}, rsp_valid, 1'b0);
    chk({tag, "_rdy_back"}, req_ready, 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ms_tick = 1'b1;
      @(negedge clk) ms_tick = 1'b0;
    end
  endtask

  initial begin
    int s0, n, bad;
    logic [7:0]  h_code;
    logic [15:0] h_data;
    logic [4:0]  h_sens;

    reset_n = 1'b1; ms_tick = 1'b0; req_valid = 1'b0; req_sensor = '0; req_cmd = '0;
    rsp_ready = 1'b0; rd_done = 1'b0; rd_error = 1'b0;
    rd_hum_int = '0; rd_hum_float = '0; rd_temp_int = '0; rd_temp_float = '0; rd_check_sum = '0;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_code", rsp_code, 8'h00);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_sensor", rsp_sensor, 5'd0);
    chk("rst_rd_start", rd_start, 1'b0);
    chk("rst_rd_sensor", rd_sensor, 5'd0);
    reset_n = 1'b1;

    // Good read, sensor 1, temperature.
    s0 = start_cyc;
    send_req(5'd1, 2'd0);
    run_read("ok_s1", 5'd1, 1'b0, 8'h28, 8'h00, 8'h19, 8'h05, 8'h46);
    chk("ok_s1_start_width", start_cyc - s0, 1);
    take_rsp("ok_s1", 8'h00, 16'h1905, 5'd1);

    // Sensor 2 while sensor 1 is in holdoff; bad checksum, humidity payload.
    s0 = start_cyc;
    send_req(5'd2, 2'd1);
    run_read("csum_s2", 5'd2, 1'b0, 8'h28, 8'h00, 8'h19, 8'h05, 8'h47);
    chk("csum_s2_start_width", start_cyc - s0, 1);
    take_rsp("csum_s2", 8'h02, 16'h2800, 5'd2);

    // Reader error, checksum-byte payload.
    send_req(5'd3, 2'd2);
    run_read("err_s3", 5'd3, 1'b1, 8'h28, 8'h00, 8'h19, 8'h05, 8'h46);
    take_rsp("err_s3", 8'h01, 16'h0046, 5'd3);

    // Rejects: no reader access.
    s0 = start_cyc;
    send_req(5'd4, 2'd0);
    expect_reject_latency("bad_sensor");
    take_rsp("bad_sensor", 8'h04, 16'h0000, 5'd4);
    send_req(5'd0, 2'd3);
    expect_reject_latency("bad_cmd");
    take_rsp("bad_cmd", 8'h06, 16'h0000, 5'd0);
    send_req(5'd5, 2'd3);
    expect_reject_latency("prio_sensor");
    take_rsp("prio_sensor", 8'h04, 16'h0000, 5'd5);
    send_req(5'd1, 2'd3);
    expect_reject_latency("prio_cmd");
    take_rsp("prio_cmd", 8'h06, 16'h0000, 5'd1);
    chk("reject_no_start", start_cyc - s0, 0);

    // Holdoff boundary on sensor 1.
    ticks(1999);
    s0 = start_cyc;
    send_req(5'd1, 2'd0);
    expect_reject_latency("hold_1999");
    take_rsp("hold_1999", 8'h05, 16'h0000, 5'd1);
    chk("hold_1999_no_start", start_cyc - s0, 0);
    ticks(1);
    send_req(5'd1, 2'd1);
    run_read("hold_2000", 5'd1, 1'b0, 8'h28, 8'h00, 8'h19, 8'h05, 8'h46);

    // Response held off by the host for 50 cycles.
    h_code = rsp_code; h_data = rsp_data; h_sens = rsp_sensor;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_code !== h_code ||
          rsp_data !== h_data || rsp_sensor !== h_sens) bad++;
    end
    chk("stall_stable", bad, 0);
    take_rsp("hold_2000", 8'h00, 16'h2800, 5'd1);

    // Watchdog: the reader never answers.
    send_req(5'd0, 2'd0);
    wait_start("tmo");
    n = 0;
    while (rsp_valid !== 1'b1 && n < 31000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 30001);
    chk("tmo_code", rsp_code, 8'h03);
    chk("tmo_sensor", rsp_sensor, 5'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("tmo_vld_drop", rsp_valid, 1'b0);
    s0 = start_cyc;
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    chk("late_done_ignored", bad, 0);
    chk("late_done_no_start", start_cyc - s0, 0);
    send_req(5'd0, 2'd0);
    expect_reject_latency("tmo_hold");
    take_rsp("tmo_hold", 8'h05, 16'h0000, 5'd0);

    // Asynchronous reset in WAIT_RD.
    send_req(5'd2, 2'd0);
    wait_start("arst");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1'b1);
    chk("arst_rsp_code", rsp_code, 8'h00);
    chk("arst_rd_sensor", rd_sensor, 5'd0);
    chk("arst_rd_start", rd_start, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    chk("arst_done_ignored", bad, 0);
    // Sensor 1 was in holdoff before reset; it must now be accepted.
    send_req(5'd1, 2'd2);
    run_read("arst_hold_clr", 5'd1, 1'b0, 8'h28, 8'h00, 8'h19, 8'h05, 8'h46);
    take_rsp("arst_hold_clr", 8'h00, 16'h0046, 5'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
